// File: rtl/rv32_mod_mem_arbiter.sv
// Memory bus arbiter: shares one bus between instruction fetch (I) and load/store (D), D has priority.
// Optional bus timeout abort is built when RV32_MEM_ARB_TIMEOUT_EN is defined.
module rv32_mod_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [2:0]        d_type,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_r, state_n;
    logic [1:0]  off_r;
    logic [2:0]  type_r;
    logic        d_bad_s;
    logic [3:0]  d_be_s;
    logic [31:0] d_wdata_s;
    logic [31:0] lane_s;
    logic [31:0] load_ext_s;
    logic        abort_s;

`ifdef RV32_MEM_ARB_TIMEOUT_EN
    logic [15:0] cnt_r;

    assign abort_s = (cnt_r == 16'(TIMEOUT - 1)) && !bus_ack;

    // Bus wait counter: zero while idle so it starts fresh in every bus phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (state_r == IDLE) begin
            cnt_r <= 16'd0;
        end else if ((state_r == BUS_I || state_r == BUS_D) && !bus_ack) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT;
    assign abort_s          = 1'b0;
`endif

    // D-port decode: byte enables, lane-replicated store data, alignment/type legality
    always_comb begin
        d_be_s    = 4'b0000;
        d_wdata_s = 32'h0000_0000;
        d_bad_s   = 1'b0;
        case (d_type[1:0])
            2'b00: begin
                d_be_s    = 4'b0001 << d_addr[1:0];
                d_wdata_s = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_be_s    = 4'b0011 << d_addr[1:0];
                d_wdata_s = {2{d_wdata[15:0]}};
                d_bad_s   = d_addr[0];
            end
            2'b10: begin
                d_be_s    = 4'b1111;
                d_wdata_s = d_wdata;
                d_bad_s   = (d_addr[1:0] != 2'b00) || d_type[2];
            end
            default: begin
                d_bad_s = 1'b1;
            end
        endcase
    end

    // Load lane select and sign/zero extension using the latched offset and type
    always_comb begin
        lane_s     = bus_rdata >> {off_r, 3'b000};
        load_ext_s = bus_rdata;
        case (type_r[1:0])
            2'b00:   load_ext_s = type_r[2] ? {24'h000000, lane_s[7:0]}
                                            : {{24{lane_s[7]}}, lane_s[7:0]};
            2'b01:   load_ext_s = type_r[2] ? {16'h0000, lane_s[15:0]}
                                            : {{16{lane_s[15]}}, lane_s[15:0]};
            default: load_ext_s = bus_rdata;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (d_req) begin
                    state_n = d_bad_s ? RESP : BUS_D;
                end else if (i_req) begin
                    state_n = (i_addr[1:0] != 2'b00) ? RESP : BUS_I;
                end else begin
                    state_n = IDLE;
                end
            end
            BUS_I, BUS_D: begin
                if (bus_ack || abort_s) begin
                    state_n = RESP;
                end else begin
                    state_n = state_r;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, registered bus signals and one-cycle port responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            off_r     <= 2'b00;
            type_r    <= 3'b000;
            i_ack     <= 1'b0;
            i_rdata   <= 32'h0000_0000;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_rdata   <= 32'h0000_0000;
            d_err     <= 1'b0;
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            bus_wr    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0000_0000;
        end else begin
            state_r <= state_n;
            i_ack   <= 1'b0;
            i_rdata <= 32'h0000_0000;
            i_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_rdata <= 32'h0000_0000;
            d_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (d_req) begin
                        off_r  <= d_addr[1:0];
                        type_r <= d_type;
                        if (d_bad_s) begin
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                            bus_wr    <= d_wr;
                            bus_be    <= d_be_s;
                            bus_wdata <= d_wr ? d_wdata_s : 32'h0000_0000;
                        end
                    end else if (i_req) begin
                        if (i_addr[1:0] != 2'b00) begin
                            i_ack <= 1'b1;
                            i_err <= 1'b1;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                            bus_wr    <= 1'b0;
                            bus_be    <= 4'b1111;
                            bus_wdata <= 32'h0000_0000;
                        end
                    end
                end
                BUS_I, BUS_D: begin
                    if (bus_ack || abort_s) begin
                        bus_req   <= 1'b0;
                        bus_addr  <= '0;
                        bus_wr    <= 1'b0;
                        bus_be    <= 4'b0000;
                        bus_wdata <= 32'h0000_0000;
                        if (state_r == BUS_D) begin
                            d_ack   <= 1'b1;
                            d_err   <= abort_s | bus_err;
                            d_rdata <= (abort_s || bus_wr) ? 32'h0000_0000 : load_ext_s;
                        end else begin
                            i_ack   <= 1'b1;
                            i_err   <= abort_s | bus_err;
                            i_rdata <= abort_s ? 32'h0000_0000 : bus_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mod_mem_arbiter.sv
// Self-checking bench for rv32_mod_mem_arbiter: directed cases plus randomized D/I traffic
// against an arithmetic reference model; the timeout case runs when RV32_MEM_ARB_TIMEOUT_EN is defined.
module tb_rv32_mod_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_wr;
    logic [2:0]  d_type;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_wr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    rv32_mod_mem_arbiter #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_type(d_type), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for an illegal type code
    function automatic int m_size(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic m_bad(input logic [31:0] a, input logic [2:0] t);
        int sz = m_size(t);
        if (sz == 0) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] t);
        int v = ((1 << m_size(t)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [2:0] t);
        int sz = m_size(t);
        if (sz == 1) return (w % 256) * 32'h0101_0101;
        if (sz == 2) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] t);
        int sz = m_size(t);
        logic [63:0] full = 64'd1 << (8 * sz);
        logic [63:0] v = (64'(rd) >> (8 * (a % 4))) % full;
        if (!t[2] && v >= (full >> 1)) v = v - full;
        return v[31:0];
    endfunction

    task automatic d_txn(input logic [31:0] addr, input logic [2:0] typ, input logic wr,
                         input logic [31:0] wdata, input int delay, input logic [31:0] rd,
                         input logic err);
        @(negedge clk);
        d_req = 1'b1; d_addr = addr; d_type = typ; d_wr = wr; d_wdata = wdata;
        @(negedge clk);
        if (m_bad(addr, typ)) begin
            chk("d_bad_no_bus_req", 32'(bus_req), 32'd0);
            chk("d_bad_ack", 32'(d_ack), 32'd1);
            chk("d_bad_err", 32'(d_err), 32'd1);
            d_req = 1'b0;
        end else begin
            chk("d_bus_req", 32'(bus_req), 32'd1);
            chk("d_bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
            chk("d_bus_be", 32'(bus_be), 32'(m_be(addr, typ)));
            chk("d_bus_wr", 32'(bus_wr), 32'(wr));
            if (wr) chk("d_bus_wdata", bus_wdata, m_wdata(wdata, typ));
            for (int k = 0; k < delay; k++) begin
                @(negedge clk);
                chk("d_hold_req", 32'(bus_req), 32'd1);
                chk("d_no_early_ack", 32'(d_ack), 32'd0);
            end
            bus_ack = 1'b1; bus_rdata = rd; bus_err = err;
            @(negedge clk);
            bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
            chk("d_ack", 32'(d_ack), 32'd1);
            chk("d_bus_req_drop", 32'(bus_req), 32'd0);
            chk("d_err", 32'(d_err), 32'(err));
            if (!err) chk("d_rdata", d_rdata, wr ? 32'd0 : m_load(rd, addr, typ));
            d_req = 1'b0;
        end
        @(negedge clk);
        chk("d_ack_pulse", 32'(d_ack), 32'd0);
    endtask

    task automatic i_txn(input logic [31:0] addr, input int delay, input logic [31:0] rd, input logic err);
        @(negedge clk);
        i_req = 1'b1; i_addr = addr;
        @(negedge clk);
        if (addr % 4 != 0) begin
            chk("i_bad_no_bus_req", 32'(bus_req), 32'd0);
            chk("i_bad_ack", 32'(i_ack), 32'd1);
            chk("i_bad_err", 32'(i_err), 32'd1);
            i_req = 1'b0;
        end else begin
            chk("i_bus_req", 32'(bus_req), 32'd1);
            chk("i_bus_addr", bus_addr, addr);
            chk("i_bus_be", 32'(bus_be), 32'hF);
            chk("i_bus_wr", 32'(bus_wr), 32'd0);
            repeat (delay) @(negedge clk);
            bus_ack = 1'b1; bus_rdata = rd; bus_err = err;
            @(negedge clk);
            bus_ack = 1'b0; bus_err = 1'b0;
            chk("i_ack", 32'(i_ack), 32'd1);
            chk("i_err", 32'(i_err), 32'(err));
            chk("i_rdata", i_rdata, rd);
            i_req = 1'b0;
        end
        @(negedge clk);
        chk("i_ack_pulse", 32'(i_ack), 32'd0);
    endtask

    initial begin
        int waited;
        logic [31:0] a;
        logic [2:0]  t;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_addr = 32'd0; d_wr = 1'b0; d_type = 3'b000; d_wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_i_ack", 32'(i_ack), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        rst = 1'b0;

        // Directed cases
        d_txn(32'h100, 3'b010, 1'b0, 32'd0, 2, 32'hDEADBEEF, 1'b0);
        chk("lw_rdata_const", d_rdata, 32'd0);
        d_txn(32'h103, 3'b000, 1'b0, 32'd0, 1, 32'h8012_3456, 1'b0);
        d_txn(32'h103, 3'b100, 1'b0, 32'd0, 0, 32'h8012_3456, 1'b0);
        d_txn(32'h102, 3'b001, 1'b1, 32'h0000_ABCD, 1, 32'd0, 1'b0);
        d_txn(32'h101, 3'b010, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        d_txn(32'h100, 3'b111, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        d_txn(32'h200, 3'b010, 1'b0, 32'd0, 0, 32'h1234_5678, 1'b1);
        i_txn(32'h400, 1, 32'hCAFE_F00D, 1'b0);
        i_txn(32'h402, 0, 32'd0, 1'b0);

        // Simultaneous I and D: D first, then I
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0800;
        d_req = 1'b1; d_addr = 32'h0000_0904; d_type = 3'b010; d_wr = 1'b0;
        @(negedge clk);
        chk("sim_first_is_d", bus_addr, 32'h0000_0904);
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("sim_d_ack", 32'(d_ack), 32'd1);
        chk("sim_no_i_ack", 32'(i_ack), 32'd0);
        chk("sim_d_rdata", d_rdata, 32'h1111_2222);
        d_req = 1'b0;
        waited = 0;
        while (!bus_req && waited < 10) begin
            @(negedge clk);
            waited++;
            chk("sim_no_d_reack", 32'(d_ack), 32'd0);
        end
        chk("sim_i_bus_req", 32'(bus_req), 32'd1);
        chk("sim_i_bus_addr", bus_addr, 32'h0000_0800);
        bus_ack = 1'b1; bus_rdata = 32'h3333_4444;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("sim_i_ack", 32'(i_ack), 32'd1);
        chk("sim_i_rdata", i_rdata, 32'h3333_4444);
        i_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a D bus cycle
        d_req = 1'b1; d_addr = 32'h0000_0300; d_type = 3'b010; d_wr = 1'b0;
        @(negedge clk);
        chk("mid_rst_bus_req_pre", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
        d_req = 1'b0;
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_ack", 32'(d_ack), 32'd0);
            chk("mid_rst_idle", 32'(bus_req), 32'd0);
        end

`ifdef RV32_MEM_ARB_TIMEOUT_EN
        // Bus never acknowledges: abort after TIMEOUT cycles
        d_req = 1'b1; d_addr = 32'h0000_0500; d_type = 3'b010; d_wr = 1'b0;
        @(negedge clk);
        waited = 0;
        while (bus_req && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        chk("to_req_cycles", 32'(waited), 32'd4);
        chk("to_d_ack", 32'(d_ack), 32'd1);
        chk("to_d_err", 32'(d_err), 32'd1);
        chk("to_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        @(negedge clk);
`endif

        // Randomized D traffic
        for (int n = 0; n < 40; n++) begin
            a = 32'h1000 + $urandom_range(0, 255);
            t = 3'($urandom_range(0, 7));
            d_txn(a, t, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                  $urandom, ($urandom_range(0, 7) == 0));
        end
        // Randomized I traffic
        for (int n = 0; n < 12; n++) begin
            a = 32'h2000 + $urandom_range(0, 63);
            i_txn(a, $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
